unidade_controle: RTL and testbench
===================================

# unidade_controle

Multicycle control unit for the 16-bit processor datapath: fetches instruction words from synchronous memory, latches them into the instruction register, and sequences execution. Sits directly upstream of the PC register (R7) and the general registers. Drives the PC's load and increment strobes, register-file enables, ALU/G controls, and the memory address/data registers.

## Interface
Parameters:
- none; all widths fixed at 16-bit data, 8 registers, 3-bit opcode.

Ports:
- Clock  in  1  system clock; all state changes on posedge.
- Resetn  in  1  asynchronous, active-high reset (despite the name); forces state F0 and all outputs low.
- Run  in  1  level; enables a new instruction fetch in F0.
- DIN  in  16  memory read data; instruction field is DIN[15:7].
- GNZ  in  1  G register non-zero flag, from datapath.
- IRin  out  1  load instruction register from DIN.
- IncrPc  out  1  single-cycle PC increment strobe.
- R_in  out  8  one-hot register load enables; R_in[7] is the PC Rin.
- R_out  out  8  one-hot bus-drive enables; R_out[7] drives PC onto bus.
- DINout, Gout  out  1 each  bus-drive enables.
- Ain, Gin, AddSub  out  1 each  A load, G load, subtract select (1 = sub).
- ADDRin, DOUTin, W_D  out  1 each  address register load, data-out register load, memory write.
- Done  out  1  pulse in final cycle of each instruction.

## Operation
- Instruction format (IR[8:0] = DIN[15:7] at IRin): III = IR[8:6], X = IR[5:3], Y = IR[2:0].
- Opcodes: 000 mv, 001 mvi, 010 add, 011 sub, 100 ld, 101 st, 110 mvnz, 111 nop.
- States: F0, F1, F2, E1, E2, E3. Moore outputs decoded from state and IR only; at most one R_out bit, DINout or Gout active per cycle.
- F0: if Run=1, assert R_out[7], ADDRin, IncrPc and go to F1; else hold with all outputs 0.
- F1: no outputs (memory latency cycle) -> F2.
- F2: IRin -> E1.
- mv: E1 R_out[Y], R_in[X], Done -> F0.
- mvi: E1 R_out[7], ADDRin, IncrPc; E2 wait; E3 DINout, R_in[X], Done -> F0.
- add/sub: E1 R_out[X], Ain; E2 R_out[Y], Gin, AddSub = opcode[0]; E3 Gout, R_in[X], Done -> F0.
- ld: E1 R_out[Y], ADDRin; E2 wait; E3 DINout, R_in[X], Done -> F0.
- st: E1 R_out[Y], ADDRin; E2 R_out[X], DOUTin; E3 W_D, Done -> F0.
- mvnz: E1 if GNZ then R_out[Y], R_in[X]; Done always -> F0.
- nop: E1 Done -> F0.
- X or Y = 7 is legal: mv/mvnz/ld into R7 are jumps. R_in[7] and IncrPc are never asserted in the same cycle.

## Timing
- Reset value: state F0, IR = 0, every output 0. Reset mid-instruction aborts it immediately; no Done.
- Instruction latency from F0 with Run=1: mv/mvnz/nop 4 cycles, mvi/add/sub/ld/st 6 cycles.
- Done is high exactly one cycle, in the last execute state. F0 follows, and the next fetch may start that cycle.
- IncrPc is high for exactly one cycle per assertion, so the PC increments once per fetch and once more for mvi.
- Run dropped mid-instruction: the instruction completes; the FSM then idles in F0.
- GNZ is sampled only in mvnz E1.

## Structure
- Shared package: opcode constants (OP_MV … OP_NOP), state encoding constants (F0…E3), register index constant PC_IDX = 7.
- One sub-module, dec3to8 (3-bit to one-hot 8 with enable), used for R_in and R_out.
- Output decode is purely combinational from registered state and IR. There are no other registers.

## Test plan
- Reset asserted in E2 of add: all outputs 0 within the same cycle. After release, the FSM is in F0 and Done never pulses.
- Run=1, DIN=16'h2000 (mvi R0) then 16'h0005: IncrPc pulses in F0 and E1. R_in[0] and DINout are high together in E3. Done follows after 6 cycles.
- sub R1,R2 (DIN[15:7]=9'b011_001_010): E1 R_out[1]+Ain, E2 R_out[2]+Gin+AddSub=1, E3 Gout+R_in[1]+Done.
- mvnz R7,R3 with GNZ=0: R_in is 0 in E1 and Done=1. Repeat with GNZ=1: R_out[3] and R_in[7] are high, and IncrPc stays 0.
- st R4,R5: ADDRin with R_out[5] in E1, DOUTin with R_out[4] in E2, W_D only in E3.
- Run=0 in F0 for 10 cycles: no output toggles. Raising Run starts the fetch on the next edge.

Source files
------------

// File: rtl/unidade_controle_pkg.sv
// unidade_controle_pkg: opcodes, FSM states and register indices shared by the control unit
package unidade_controle_pkg;
  typedef enum logic [2:0] {F0, F1, F2, E1, E2, E3} state_t;
  localparam logic [2:0] OP_MV   = 3'd0;
  localparam logic [2:0] OP_MVI  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_LD   = 3'd4;
  localparam logic [2:0] OP_ST   = 3'd5;
  localparam logic [2:0] OP_MVNZ = 3'd6;
  localparam logic [2:0] OP_NOP  = 3'd7;
  localparam logic [2:0] PC_IDX  = 3'd7;
endpackage

// File: rtl/unidade_controle_dec3to8.sv
// dec3to8: 3-bit index to one-hot 8 with enable
module dec3to8 (
  input  logic       en,
  input  logic [2:0] sel,
  output logic [7:0] y
);
  assign y = en ? 8'b1 << sel : 8'b0;
endmodule

// File: rtl/unidade_controle.sv
// unidade_controle: multicycle fetch/execute sequencer for the 16-bit datapath
module unidade_controle
  import unidade_controle_pkg::*;
(
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Run,
  input  logic [15:0] DIN,
  input  logic        GNZ,
  output logic        IRin,
  output logic        IncrPc,
  output logic [7:0]  R_in,
  output logic [7:0]  R_out,
  output logic        DINout,
  output logic        Gout,
  output logic        Ain,
  output logic        Gin,
  output logic        AddSub,
  output logic        ADDRin,
  output logic        DOUTin,
  output logic        W_D,
  output logic        Done
);
  state_t state, next;
  logic [8:0] ir;
  logic [2:0] op, x, y, ro_sel, ri_sel;
  logic ro_en, ri_en;
  logic unused_din;
  assign unused_din = ^DIN[6:0];
  assign op = ir[8:6];
  assign x  = ir[5:3];
  assign y  = ir[2:0];
  dec3to8 u_rin  (.en(ri_en), .sel(ri_sel), .y(R_in));
  dec3to8 u_rout (.en(ro_en), .sel(ro_sel), .y(R_out));
  always_comb begin
    next = state;
    {IRin, IncrPc, DINout, Gout, Ain, Gin, AddSub, ADDRin, DOUTin, W_D, Done} = '0;
    ro_en = 1'b0;
    ro_sel = PC_IDX;
    ri_en = 1'b0;
    ri_sel = x;
    case (state)
      F0: if (Run) begin
        ro_en = 1'b1;
        ADDRin = 1'b1;
        IncrPc = 1'b1;
        next = F1;
      end
      F1: next = F2;
      F2: begin
        IRin = 1'b1;
        next = E1;
      end
      E1: begin
        next = E2;
        case (op)
          OP_MV: begin
            ro_en = 1'b1; ro_sel = y; ri_en = 1'b1; Done = 1'b1; next = F0;
          end
          OP_MVI: begin
            ro_en = 1'b1; ADDRin = 1'b1; IncrPc = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            ro_en = 1'b1; ro_sel = x; Ain = 1'b1;
          end
          OP_LD, OP_ST: begin
            ro_en = 1'b1; ro_sel = y; ADDRin = 1'b1;
          end
          OP_MVNZ: begin
            ro_en = GNZ; ro_sel = y; ri_en = GNZ; Done = 1'b1; next = F0;
          end
          default: begin
            Done = 1'b1; next = F0;
          end
        endcase
      end
      E2: begin
        next = E3;
        if (op == OP_ADD || op == OP_SUB) begin
          ro_en = 1'b1; ro_sel = y; Gin = 1'b1; AddSub = op[0];
        end else if (op == OP_ST) begin
          ro_en = 1'b1; ro_sel = x; DOUTin = 1'b1;
        end
      end
      E3: begin
        next = F0;
        Done = 1'b1;
        DINout = op == OP_MVI || op == OP_LD;
        Gout = op == OP_ADD || op == OP_SUB;
        ri_en = DINout || Gout;
        W_D = op == OP_ST;
      end
      default: next = F0;
    endcase
  end
  always_ff @(posedge Clock or posedge Resetn)
    if (Resetn) begin
      state <= F0;
      ir <= '0;
    end else begin
      state <= next;
      if (IRin) ir <= DIN[15:7];
    end
endmodule

// File: tb/tb_unidade_controle.sv
// tb_unidade_controle: scoreboard bench comparing per-cycle control outputs
module tb_unidade_controle;
  typedef struct packed {
    logic irin, incr;
    logic [7:0] rin, rout;
    logic dinout, gout, ain, gin, addsub, addrin, doutin, wd, done;
  } ov_t;
  logic Clock = 0, Resetn = 1, Run = 0, GNZ = 0;
  logic [15:0] DIN = '0;
  logic IRin, IncrPc, DINout, Gout, Ain, Gin, AddSub, ADDRin, DOUTin, W_D, Done;
  logic [7:0] R_in, R_out;
  ov_t obs;
  ov_t exp_q[$];
  string tag_q[$];
  int checks = 0, errors = 0;
  unidade_controle dut (
    .Clock(Clock), .Resetn(Resetn), .Run(Run), .DIN(DIN), .GNZ(GNZ),
    .IRin(IRin), .IncrPc(IncrPc), .R_in(R_in), .R_out(R_out),
    .DINout(DINout), .Gout(Gout), .Ain(Ain), .Gin(Gin), .AddSub(AddSub),
    .ADDRin(ADDRin), .DOUTin(DOUTin), .W_D(W_D), .Done(Done)
  );
  assign obs = {IRin, IncrPc, R_in, R_out, DINout, Gout, Ain, Gin, AddSub, ADDRin, DOUTin, W_D, Done};
  always #5 Clock = ~Clock;
  task automatic check(input string tag, input ov_t got, input ov_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, want);
    end
  endtask
  always @(negedge Clock)
    if (exp_q.size() > 0) check(tag_q.pop_front(), obs, exp_q.pop_front());
  task automatic cyc(input string tag, input logic run, input logic gnz, input logic [15:0] din, input ov_t e);
    @(posedge Clock);
    #1;
    Run = run;
    GNZ = gnz;
    DIN = din;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask
  task automatic run_instr(input string name, input logic [8:0] ir, input logic gnz, input int limit);
    ov_t seq[6];
    int n;
    logic [2:0] op, x, y;
    op = ir[8:6]; x = ir[5:3]; y = ir[2:0];
    foreach (seq[i]) seq[i] = '0;
    seq[0].rout = 8'h80; seq[0].addrin = 1; seq[0].incr = 1;
    seq[2].irin = 1;
    n = 6;
    case (op)
      3'd0: begin seq[3].rout = 8'b1 << y; seq[3].rin = 8'b1 << x; seq[3].done = 1; n = 4; end
      3'd1: begin
        seq[3].rout = 8'h80; seq[3].addrin = 1; seq[3].incr = 1;
        seq[5].dinout = 1; seq[5].rin = 8'b1 << x; seq[5].done = 1;
      end
      3'd2, 3'd3: begin
        seq[3].rout = 8'b1 << x; seq[3].ain = 1;
        seq[4].rout = 8'b1 << y; seq[4].gin = 1; seq[4].addsub = op[0];
        seq[5].gout = 1; seq[5].rin = 8'b1 << x; seq[5].done = 1;
      end
      3'd4: begin
        seq[3].rout = 8'b1 << y; seq[3].addrin = 1;
        seq[5].dinout = 1; seq[5].rin = 8'b1 << x; seq[5].done = 1;
      end
      3'd5: begin
        seq[3].rout = 8'b1 << y; seq[3].addrin = 1;
        seq[4].rout = 8'b1 << x; seq[4].doutin = 1;
        seq[5].wd = 1; seq[5].done = 1;
      end
      3'd6: begin
        if (gnz) begin seq[3].rout = 8'b1 << y; seq[3].rin = 8'b1 << x; end
        seq[3].done = 1; n = 4;
      end
      default: begin seq[3].done = 1; n = 4; end
    endcase
    for (int i = 0; i < n && i < limit; i++)
      cyc($sformatf("%s_c%0d", name, i), i == 0, gnz, (op == 3'd1 && i >= 4) ? 16'h0005 : {ir, 7'b0}, seq[i]);
  endtask
  initial begin
    #1;
    check("reset_outputs", obs, '0);
    @(posedge Clock);
    #1 Resetn = 0;
    for (int i = 0; i < 10; i++) cyc($sformatf("idle_%0d", i), 0, 1, 16'hffff, '0);
    run_instr("mvi_r0", 9'b001_000_000, 0, 6);
    run_instr("sub_r1_r2", 9'b011_001_010, 0, 6);
    run_instr("mvnz_gnz0", 9'b110_111_011, 0, 6);
    run_instr("mvnz_gnz1", 9'b110_111_011, 1, 6);
    run_instr("st_r4_r5", 9'b101_100_101, 0, 6);
    run_instr("mv_r7_r0", 9'b000_111_000, 0, 6);
    run_instr("ld_r3_r6", 9'b100_011_110, 1, 6);
    run_instr("add_r2_r7", 9'b010_010_111, 0, 6);
    run_instr("nop", 9'b111_000_000, 0, 6);
    run_instr("add_abort", 9'b010_001_010, 0, 4);
    @(posedge Clock);
    #1 Resetn = 1;
    Run = 0;
    exp_q.push_back('0);
    tag_q.push_back("abort_e2");
    #1 check("abort_async", obs, '0);
    cyc("abort_hold", 0, 0, 16'h0, '0);
    Resetn = 0;
    for (int i = 0; i < 3; i++) cyc($sformatf("post_abort_%0d", i), 0, 0, 16'h0, '0);
    run_instr("mv_r1_r2", 9'b000_001_010, 0, 6);
    cyc("tail_idle", 0, 0, 16'h0, '0);
    repeat (2) @(negedge Clock);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
